// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and keeps one fetch outstanding to the I-cache.
// Returned words go into a small {pc, word} buffer for decode; supports redirect flush and halt-on-marker.
//
// state | meaning
// RUN   | issuing fetches while the buffer has room
// FULL  | buffer full, no request presented
// DRAIN | redirect arrived mid-request; old word still owed and will be dropped
// HALT  | marker word fetched; no requests until a redirect
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] instructionAddress,
  output logic        req_valid,
  input  logic        resp_valid,
  input  logic [31:0] instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic        halted
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_FULL  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]       r_state, w_state_next;
  logic [31:0]      r_pc;
  logic [31:0]      r_drain_addr;
  logic [31:0]      r_buf_instr [FIFO_DEPTH];
  logic [31:0]      r_buf_pc    [FIFO_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0] r_count, w_count_next;
  logic             w_complete, w_is_halt, w_push, w_pop;
  logic [31:0]      w_redirect_pc;
  logic             w_unused_pc_lsbs;

  assign w_redirect_pc    = {redirect_pc[31:2], 2'b00};
  assign w_unused_pc_lsbs = ^redirect_pc[1:0];

  assign w_complete = req_valid && resp_valid;
  assign w_is_halt  = (instruction == HALT_WORD);
  assign w_push     = w_complete && !redirect_valid && (r_state == S_RUN) && !w_is_halt;
  assign w_pop      = if_valid && if_ready && !redirect_valid;

  assign if_valid           = (r_count != '0);
  assign if_instruction     = r_buf_instr[r_rd_ptr];
  assign if_pc              = r_buf_pc[r_rd_ptr];
  assign halted             = (r_state == S_HALT);
  assign instructionAddress = (r_state == S_DRAIN) ? r_drain_addr : r_pc;

  always_comb begin
    req_valid = 1'b0;
    case (r_state)
      S_RUN:   req_valid = (r_count < DEPTH_C);
      S_DRAIN: req_valid = 1'b1;
      default: req_valid = 1'b0;
    endcase
  end

  always_comb begin
    w_count_next = r_count;
    if (redirect_valid)
      w_count_next = '0;
    else if (w_push && !w_pop)
      w_count_next = r_count + 1'b1;
    else if (!w_push && w_pop)
      w_count_next = r_count - 1'b1;
  end

  // Redirect overrides everything; DRAIN only when the cache still owes a word.
  always_comb begin
    w_state_next = r_state;
    if (redirect_valid) begin
      w_state_next = (req_valid && !resp_valid) ? S_DRAIN : S_RUN;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_complete && w_is_halt)
            w_state_next = S_HALT;
          else if (w_count_next == DEPTH_C)
            w_state_next = S_FULL;
        end
        S_FULL: begin
          if (w_count_next < DEPTH_C)
            w_state_next = S_RUN;
        end
        S_DRAIN: begin
          if (w_complete)
            w_state_next = S_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_RUN;
      r_pc         <= {RESET_PC[31:2], 2'b00};
      r_drain_addr <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_buf_instr[i] <= '0;
        r_buf_pc[i]    <= '0;
      end
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      if (redirect_valid) begin
        r_pc         <= w_redirect_pc;
        r_drain_addr <= instructionAddress;
        r_rd_ptr     <= '0;
        r_wr_ptr     <= '0;
      end else begin
        if (w_push) begin
          r_buf_instr[r_wr_ptr] <= instruction;
          r_buf_pc[r_wr_ptr]    <= r_pc;
          r_wr_ptr              <= r_wr_ptr + 1'b1;
          r_pc                  <= r_pc + 32'd4;
        end
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural I-cache with programmable wait states,
// scoreboard of expected {pc, word} entries popped and compared at the decode side.
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instructionAddress;
  logic        req_valid;
  logic        resp_valid;
  logic [31:0] instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic        halted;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  ent_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cache_delay = 0;
  bit          halt_en = 1'b0;
  logic [31:0] halt_addr = 32'h0;
  logic [31:0] bad_pc = 32'hDEAD_BEE1;
  bit          seen_bad = 1'b0;
  bit          discard = 1'b0;
  logic [31:0] exp_addr = 32'h0;
  logic [31:0] last_pop_pc = 32'h0;
  int          n_comp = 0;
  int          n_pop = 0;

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(4),
    .HALT_WORD (32'hFFFF_FFFF)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .instructionAddress(instructionAddress),
    .req_valid         (req_valid),
    .resp_valid        (resp_valid),
    .instruction       (instruction),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .if_valid          (if_valid),
    .if_ready          (if_ready),
    .if_instruction    (if_instruction),
    .if_pc             (if_pc),
    .halted            (halted)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (halt_en && a == halt_addr) return HALT_W;
    case (a)
      32'h0:   return 32'h0040_0093;
      32'h4:   return 32'h00A0_0113;
      32'h8:   return 32'h0090_0193;
      default: return a ^ 32'h5A5A_0013;
    endcase
  endfunction

  // Cache: answers the held address after cache_delay waiting cycles.
  initial begin : cache_model
    int          busy;
    bit          prev_req;
    bit          prev_resp;
    logic [31:0] prev_addr;
    busy = 0; prev_req = 1'b0; prev_resp = 1'b0; prev_addr = '0;
    resp_valid = 1'b0;
    instruction = '0;
    forever begin
      @(negedge clock); #1;
      if (reset || !req_valid) begin
        busy = 0;
        resp_valid = 1'b0;
      end else begin
        if (!prev_req || prev_resp || instructionAddress != prev_addr) busy = 0;
        else busy++;
        resp_valid = (busy >= cache_delay);
        instruction = mem_word(instructionAddress);
      end
      prev_req = req_valid && !reset;
      prev_resp = resp_valid;
      prev_addr = instructionAddress;
    end
  end

  // Scoreboard: sampled 1 ns before each rising edge.
  initial begin : monitor
    ent_t e;
    forever begin
      @(negedge clock); #4;
      if (reset) begin
        sb.delete();
        discard = 1'b0;
        exp_addr = 32'h0;
        n_comp = 0;
        n_pop = 0;
        seen_bad = 1'b0;
      end else begin
        if (if_valid && if_ready && !redirect_valid) begin
          n_pop++;
          n_checks++;
          last_pop_pc = if_pc;
          if (if_pc == bad_pc) seen_bad = 1'b1;
          if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL pop_unexpected got pc=%h word=%h expected no entry", if_pc, if_instruction);
          end else begin
            e = sb.pop_front();
            if (if_pc !== e.pc || if_instruction !== e.word) begin
              n_errors++;
              $display("FAIL pop_data got pc=%h word=%h expected pc=%h word=%h",
                       if_pc, if_instruction, e.pc, e.word);
            end
          end
        end
        if (redirect_valid) begin
          sb.delete();
          discard = req_valid && !resp_valid;
          exp_addr = {redirect_pc[31:2], 2'b00};
        end else if (req_valid && resp_valid) begin
          n_comp++;
          if (discard) begin
            discard = 1'b0;
          end else begin
            n_checks++;
            if (instructionAddress !== exp_addr) begin
              n_errors++;
              $display("FAIL fetch_addr got %h expected %h", instructionAddress, exp_addr);
            end
            if (mem_word(exp_addr) != HALT_W) begin
              e.pc = exp_addr;
              e.word = mem_word(exp_addr);
              sb.push_back(e);
              exp_addr = exp_addr + 32'd4;
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  task automatic do_reset(input bit rdy, input int dly);
    @(negedge clock);
    reset = 1'b1;
    redirect_valid = 1'b0;
    if_ready = rdy;
    cache_delay = dly;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    if_ready = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++;
    if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instruction !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_fifo got valid=%b pc=%h word=%h expected 0 0 0", if_valid, if_pc, if_instruction);
    end
    n_checks++;
    if (halted !== 1'b0 || instructionAddress !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_ctrl got halted=%b addr=%h expected 0 0", halted, instructionAddress);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (req_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_req got %b expected 1", req_valid);
    end
  endtask

  task automatic test_sequential;
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h0040_0093; exp_w[1] = 32'h00A0_0113; exp_w[2] = 32'h0090_0193;
    do_reset(1'b1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'(i * 4) || if_instruction !== exp_w[i]) begin
        n_errors++;
        $display("FAIL seq_head%0d got v=%b pc=%h word=%h expected 1 %h %h",
                 i, if_valid, if_pc, if_instruction, 32'(i * 4), exp_w[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    do_reset(1'b0, 0);
    repeat (6) @(negedge clock);
    n_checks++;
    if (n_comp != 4) begin
      n_errors++;
      $display("FAIL bp_pushes got %0d expected 4", n_comp);
    end
    n_checks++;
    if (req_valid !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h0) begin
      n_errors++;
      $display("FAIL bp_full got req=%b valid=%b pc=%h expected 0 1 0", req_valid, if_valid, if_pc);
    end
    if_ready = 1'b1;
    @(negedge clock);
    n_checks++;
    if (req_valid !== 1'b1 || instructionAddress !== 32'h10) begin
      n_errors++;
      $display("FAIL bp_resume got req=%b addr=%h expected 1 00000010", req_valid, instructionAddress);
    end
    repeat (8) @(negedge clock);
    n_checks++;
    if (n_pop != 9 || last_pop_pc !== 32'h20) begin
      n_errors++;
      $display("FAIL bp_drain got pops=%0d last=%h expected 9 00000020", n_pop, last_pop_pc);
    end
  endtask

  task automatic test_halt;
    bit ok;
    halt_en = 1'b1;
    halt_addr = 32'h20;
    bad_pc = 32'h20;
    do_reset(1'b1, 0);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (halted === 1'b1) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok || req_valid !== 1'b0 || instructionAddress !== 32'h20) begin
      n_errors++;
      $display("FAIL halt_state got halted=%b req=%b addr=%h expected 1 0 00000020",
               halted, req_valid, instructionAddress);
    end
    repeat (3) @(negedge clock);
    n_checks++;
    if (if_valid !== 1'b0 || last_pop_pc !== 32'h1C || seen_bad || sb.size() != 0) begin
      n_errors++;
      $display("FAIL halt_drain got valid=%b last=%h seen20=%b left=%0d expected 0 0000001c 0 0",
               if_valid, last_pop_pc, seen_bad, sb.size());
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clock);
    redirect_valid = 1'b0;
    n_checks++;
    if (halted !== 1'b0 || req_valid !== 1'b1 || instructionAddress !== 32'h200) begin
      n_errors++;
      $display("FAIL halt_redirect got halted=%b req=%b addr=%h expected 0 1 00000200",
               halted, req_valid, instructionAddress);
    end
    repeat (3) @(negedge clock);
    halt_en = 1'b0;
    bad_pc = 32'hDEAD_BEE1;
  endtask

  task automatic test_redirect_wait;
    bit ok;
    bad_pc = 32'h8;
    do_reset(1'b1, 3);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (req_valid && instructionAddress == 32'h8) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL rw_reach8 got addr=%h expected 00000008", instructionAddress);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h43;
    @(negedge clock);
    redirect_valid = 1'b0;
    n_checks++;
    if (if_valid !== 1'b0 || req_valid !== 1'b1 || instructionAddress !== 32'h8) begin
      n_errors++;
      $display("FAIL rw_drain got valid=%b req=%b addr=%h expected 0 1 00000008",
               if_valid, req_valid, instructionAddress);
    end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (instructionAddress == 32'h40) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok || req_valid !== 1'b1 || if_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL rw_newreq got req=%b addr=%h valid=%b expected 1 00000040 0",
               req_valid, instructionAddress, if_valid);
    end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (if_valid === 1'b1) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok || if_pc !== 32'h40 || seen_bad) begin
      n_errors++;
      $display("FAIL rw_first got pc=%h seen8=%b expected 00000040 0", if_pc, seen_bad);
    end
    bad_pc = 32'hDEAD_BEE1;
  endtask

  task automatic test_same_cycle;
    bit ok;
    bad_pc = 32'hC;
    do_reset(1'b1, 0);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (req_valid && instructionAddress == 32'hC) begin ok = 1'b1; break; end
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clock);
    redirect_valid = 1'b0;
    n_checks++;
    if (!ok || instructionAddress !== 32'h100 || req_valid !== 1'b1 || if_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL sc_redirect got addr=%h req=%b valid=%b expected 00000100 1 0",
               instructionAddress, req_valid, if_valid);
    end
    repeat (4) @(negedge clock);
    n_checks++;
    if (seen_bad || last_pop_pc !== 32'h108) begin
      n_errors++;
      $display("FAIL sc_stream got seenC=%b last=%h expected 0 00000108", seen_bad, last_pop_pc);
    end
    bad_pc = 32'hDEAD_BEE1;
  endtask

  task automatic test_async_reset;
    do_reset(1'b0, 0);
    repeat (3) @(negedge clock);
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || req_valid !== 1'b1 || instructionAddress !== 32'hC) begin
      n_errors++;
      $display("FAIL ar_pre got valid=%b pc=%h req=%b addr=%h expected 1 0 1 0000000c",
               if_valid, if_pc, req_valid, instructionAddress);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (if_valid !== 1'b0 || halted !== 1'b0 || instructionAddress !== 32'h0 || if_pc !== 32'h0) begin
      n_errors++;
      $display("FAIL ar_immediate got valid=%b halted=%b addr=%h pc=%h expected 0 0 0 0",
               if_valid, halted, instructionAddress, if_pc);
    end
    @(negedge clock);
    if_ready = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || instructionAddress !== 32'h4) begin
      n_errors++;
      $display("FAIL ar_restart got valid=%b pc=%h addr=%h expected 1 0 00000004",
               if_valid, if_pc, instructionAddress);
    end
  endtask

  task automatic test_wrap;
    do_reset(1'b1, 0);
    @(negedge clock);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clock);
    redirect_valid = 1'b0;
    n_checks++;
    if (instructionAddress !== 32'hFFFF_FFFC) begin
      n_errors++;
      $display("FAIL wrap_start got %h expected fffffffc", instructionAddress);
    end
    @(negedge clock);
    n_checks++;
    if (instructionAddress !== 32'h0 || if_pc !== 32'hFFFF_FFFC) begin
      n_errors++;
      $display("FAIL wrap_next got addr=%h pc=%h expected 0 fffffffc", instructionAddress, if_pc);
    end
    @(negedge clock);
    n_checks++;
    if (if_pc !== 32'h0 || if_instruction !== 32'h0040_0093) begin
      n_errors++;
      $display("FAIL wrap_head got pc=%h word=%h expected 0 00400093", if_pc, if_instruction);
    end
  endtask

  initial begin
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    if_ready = 1'b0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_halt();
    test_redirect_wait();
    test_same_cycle();
    test_async_reset();
    test_wrap();
    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
